// File: rtl/serial_word_loader.sv
// Serial-to-parallel feeder for the 16-bit storage register: shifts WIDTH bits in, then one write cycle and one read-back cycle.
// Optional even-parity bit after the data when PARITY_CHECK_EN is defined; otherwise parity_err is tied low.
module serial_word_loader #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] write_port_1,
    output logic             choice,
    output logic             busy,
    output logic             word_done,
    output logic             overrun,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef PARITY_CHECK_EN
    typedef enum logic [2:0] {IDLE, SHIFT, PARITY, WRITE, READBACK} state_t;
`else
    typedef enum logic [2:0] {IDLE, SHIFT, WRITE, READBACK} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] wp_q, wp_d;
    logic             choice_q, choice_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] fresh_word;
    logic [WIDTH-1:0] shifted_word;
    logic             start;

`ifdef PARITY_CHECK_EN
    logic par_q, par_d;
    logic perr_q, perr_d;
`endif

    assign start = ser_valid && frame_start;

    // A restart always begins from a clean word so stale bits never leak through.
    always_comb begin
        fresh_word   = '0;
        shifted_word = '0;
        if (MSB_FIRST) begin
            fresh_word   = {{(WIDTH-1){1'b0}}, ser_in};
            shifted_word = {shift_q[WIDTH-2:0], ser_in};
        end else begin
            fresh_word   = {ser_in, {(WIDTH-1){1'b0}}};
            shifted_word = {ser_in, shift_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;
`ifdef PARITY_CHECK_EN
        par_d     = par_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = fresh_word;
                    cnt_d   = CW'(1);
`ifdef PARITY_CHECK_EN
                    par_d   = ser_in;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (start) begin
                    shift_d   = fresh_word;
                    cnt_d     = CW'(1);
                    overrun_d = 1'b1;
`ifdef PARITY_CHECK_EN
                    par_d     = ser_in;
`endif
                end else if (ser_valid) begin
                    shift_d = shifted_word;
                    cnt_d   = cnt_q + CW'(1);
`ifdef PARITY_CHECK_EN
                    par_d   = par_q ^ ser_in;
`endif
                    if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef PARITY_CHECK_EN
                        state_d = PARITY;
`else
                        state_d = WRITE;
`endif
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
                if (start) begin
                    shift_d   = fresh_word;
                    cnt_d     = CW'(1);
                    overrun_d = 1'b1;
                    par_d     = ser_in;
                    state_d   = SHIFT;
                end else if (ser_valid) begin
                    if ((par_q ^ ser_in) == 1'b0) begin
                        state_d = WRITE;
                    end else begin
                        perr_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`endif
            WRITE:    state_d = READBACK;
            READBACK: state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // Outputs are registered off the next state so they line up with it.
        wp_d     = (state_d == WRITE) ? shift_d : wp_q;
        choice_d = (state_d != WRITE);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == READBACK);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            wp_q      <= '0;
            choice_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef PARITY_CHECK_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            wp_q      <= wp_d;
            choice_q  <= choice_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
`ifdef PARITY_CHECK_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign write_port_1 = wp_q;
    assign choice       = choice_q;
    assign busy         = busy_q;
    assign word_done    = done_q;
    assign overrun      = overrun_q;
`ifdef PARITY_CHECK_EN
    assign parity_err   = perr_q;
`else
    assign parity_err   = 1'b0;
`endif

endmodule
